ascon_crypt_sequencer: RTL and testbench

ASCON_CRYPT_SEQUENCER -- requirements
Module: ascon_crypt_sequencer

---
 rtl/ascon_crypt_sequencer.sv | 148 ++++++++++++++
 tb/tb_ascon_crypt_sequencer.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_crypt_sequencer.sv
// Block sequencer for an Ascon encrypt/decrypt datapath: accepts 128-bit blocks,
// runs the p8 permutation on full blocks and a final LAST step on the tail or padding block.
module ascon_crypt_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [31:0]  text_len,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [4:0]   out_bytes,
    output logic         dp_process_en,
    output logic         dp_mode_sel,
    output logic [31:0]  dp_text_length,
    output logic [31:0]  dp_text_position,
    output logic [127:0] dp_data_in,
    input  logic [127:0] dp_data_out,
    output logic         perm_start,
    input  logic         perm_done,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitIn,
        StPerm,
        StLast,
        StCapture,
        StOut,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic           mode_q;
    logic [31:0]    len_q;
    logic [31:0]    pos_q;
    logic [127:0]   data_in_q;
    logic [127:0]   out_data_q;
    logic [4:0]     out_bytes_q;
    logic           last_q;
    logic           perm_issued_q;

    logic [31:0]    rem;
    logic [4:0]     take;
    logic           in_hs;

    assign rem   = len_q - pos_q;
    assign take  = (rem < 32'd16) ? rem[4:0] : 5'd16;
    assign in_hs = in_valid && (state_q == StWaitIn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (text_len == 32'd0) ? StLast : StWaitIn;
                end
            end
            StWaitIn: begin
                if (in_valid) begin
                    state_d = (rem >= 32'd16) ? StPerm : StLast;
                end
            end
            StPerm: begin
                if (perm_done) begin
                    state_d = StCapture;
                end
            end
            StLast:    state_d = (rem == 32'd0) ? StDone : StCapture;
            StCapture: state_d = StOut;
            StOut: begin
                // pos_q has already advanced here, so rem is the remaining length
                if (out_ready) begin
                    if (last_q) begin
                        state_d = StDone;
                    end else if (rem == 32'd0) begin
                        state_d = StLast;
                    end else begin
                        state_d = StWaitIn;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == StWaitIn);
        out_valid     = (state_q == StOut);
        dp_process_en = ((state_q == StPerm) && perm_done) || (state_q == StLast);
        perm_start    = (state_q == StPerm) && !perm_issued_q;
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= 1'b0;
            len_q         <= 32'd0;
            pos_q         <= 32'd0;
            data_in_q     <= 128'd0;
            out_data_q    <= 128'd0;
            out_bytes_q   <= 5'd0;
            last_q        <= 1'b0;
            perm_issued_q <= 1'b0;
        end else begin
            // Marks every PERM cycle after the first so perm_start is a single pulse
            perm_issued_q <= (state_q == StPerm);
            if ((state_q == StIdle) && start) begin
                mode_q <= mode;
                len_q  <= text_len;
                pos_q  <= 32'd0;
                last_q <= 1'b0;
            end
            if (in_hs) begin
                data_in_q <= in_data;
            end
            if (state_q == StCapture) begin
                out_data_q  <= dp_data_out;
                out_bytes_q <= take;
                pos_q       <= pos_q + {27'd0, take};
                last_q      <= (rem < 32'd16);
            end
        end
    end

    assign out_data         = out_data_q;
    assign out_bytes        = out_bytes_q;
    assign dp_mode_sel      = mode_q;
    assign dp_text_length   = len_q;
    assign dp_text_position = pos_q;
    assign dp_data_in       = data_in_q;

endmodule

// File: tb/tb_ascon_crypt_sequencer.sv
// Self-checking bench for ascon_crypt_sequencer: random jobs compared against a
// block-level model of the message split, plus directed corner scenarios.
module tb_ascon_crypt_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [31:0]  text_len = 32'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [4:0]   out_bytes;
    logic         dp_process_en;
    logic         dp_mode_sel;
    logic [31:0]  dp_text_length;
    logic [31:0]  dp_text_position;
    logic [127:0] dp_data_in;
    logic [127:0] dp_data_out = '0;
    logic         perm_start;
    logic         perm_done;
    logic         busy;
    logic         done;

    ascon_crypt_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .mode             (mode),
        .text_len         (text_len),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_bytes        (out_bytes),
        .dp_process_en    (dp_process_en),
        .dp_mode_sel      (dp_mode_sel),
        .dp_text_length   (dp_text_length),
        .dp_text_position (dp_text_position),
        .dp_data_in       (dp_data_in),
        .dp_data_out      (dp_data_out),
        .perm_start       (perm_start),
        .perm_done        (perm_done),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_ctr = 0;
    always @(posedge clk) cyc_ctr++;

    logic [331:0] all_outs;
    assign all_outs = {in_ready, out_valid, out_data, out_bytes, dp_process_en, dp_mode_sel,
                       dp_text_length, dp_text_position, dp_data_in, perm_start, busy, done};

    // Permutation stand-in: perm_done pulses perm_lat cycles after perm_start
    int   perm_lat = 8;
    int   perm_cnt = -1;
    logic perm_auto = 1'b0;
    logic perm_spur = 1'b0;
    assign perm_done = perm_auto | perm_spur;

    always @(negedge clk) begin
        perm_auto = 1'b0;
        if (perm_cnt > 0) perm_cnt--;
        if (perm_cnt == 0) begin
            perm_auto = 1'b1;
            perm_cnt  = -1;
        end
        if (perm_start) perm_cnt = perm_lat;
    end

    // Datapath stand-in: result depends on block, position and mode
    always begin
        @(negedge clk);
        #1;
        if (dp_process_en)
            dp_data_out = dp_data_in ^ {96'd0, dp_text_position} ^ {128{dp_mode_sel}};
    end

    int unsigned mon_pe_pos[$];
    int          mon_perm_starts, mon_dones, mon_ov, mon_done_cyc;
    logic [31:0] mon_len;
    logic        mon_mode;

    always begin
        @(negedge clk);
        #2;
        if (perm_start) mon_perm_starts++;
        if (out_valid) mon_ov++;
        if (done) begin
            mon_dones++;
            mon_done_cyc = cyc_ctr;
        end
        if (dp_process_en) begin
            if (mon_pe_pos.size() == 0) begin
                mon_len  = dp_text_length;
                mon_mode = dp_mode_sel;
            end
            mon_pe_pos.push_back(dp_text_position);
        end
    end

    task automatic clear_mon();
        mon_pe_pos.delete();
        mon_perm_starts = 0;
        mon_dones = 0;
        mon_ov = 0;
        mon_done_cyc = -1;
    endtask

    // Reference model: how a message of len bytes splits into blocks and steps
    logic [127:0] blocks[$];
    logic [127:0] exp_data[$];
    logic [4:0]   exp_bytes[$];
    int unsigned  exp_pe[$];
    int           exp_nperm;

    task automatic model_job(input logic [31:0] len, input logic m);
        int unsigned pos, rem;
        int b;
        blocks.delete(); exp_data.delete(); exp_bytes.delete(); exp_pe.delete();
        exp_nperm = 0; pos = 0; b = 0;
        if (len == 0) begin
            exp_pe.push_back(0);
        end else begin
            while (1) begin
                blocks.push_back({$urandom, $urandom, $urandom, $urandom});
                rem = len - pos;
                exp_pe.push_back(pos);
                exp_data.push_back(blocks[b] ^ {96'd0, pos} ^ {128{m}});
                b++;
                if (rem >= 16) begin
                    exp_nperm++;
                    exp_bytes.push_back(5'd16);
                    pos += 16;
                    if (pos == len) begin
                        exp_pe.push_back(pos);
                        break;
                    end
                end else begin
                    exp_bytes.push_back(5'(rem));
                    break;
                end
            end
        end
    endtask

    logic [127:0] got_data[$];
    logic [4:0]   got_bytes[$];
    logic [127:0] bp_data;
    logic [4:0]   bp_bytes;
    bit           job_done;
    int           start_cyc, bp_bad, bp_cycles, spur_bad, spur_hits;

    task automatic run_job(input logic [31:0] len, input logic m, input int hold, input bit spur);
        int bi, cyc, hold_left, phase;
        bi = 0; cyc = 0; hold_left = hold; phase = 0; job_done = 0;
        got_data.delete(); got_bytes.delete();
        bp_bad = 0; bp_cycles = 0; spur_bad = 0; spur_hits = 0;
        clear_mon();
        @(negedge clk);
        start = 1'b1; mode = m; text_len = len; start_cyc = cyc_ctr;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); text_len = $urandom;
        while (!job_done && cyc < 3000) begin
            in_valid  = (bi < blocks.size()) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            if (bi < blocks.size()) in_data = blocks[bi];
            out_ready = ($urandom_range(0, 2) != 0);
            if (hold_left > 0 && out_valid) begin
                if (hold_left == hold) begin
                    bp_data  = out_data;
                    bp_bytes = out_bytes;
                end
                if (out_data !== bp_data || out_bytes !== bp_bytes || in_ready || dp_process_en)
                    bp_bad++;
                out_ready = 1'b0;
                bp_cycles++;
                hold_left--;
            end
            if (spur) begin
                case (phase)
                    0: if (out_valid) begin
                        start = 1'b1; mode = ~m; text_len = len + 7; out_ready = 1'b0; phase = 1;
                    end
                    1: begin
                        start = 1'b0; spur_hits++;
                        if (!out_valid || !busy) spur_bad++;
                        phase = 2;
                    end
                    2: if (in_ready) begin
                        in_valid = 1'b0; perm_spur = 1'b1; phase = 3;
                    end
                    3: begin
                        perm_spur = 1'b0; spur_hits++;
                        if (!in_ready) spur_bad++;
                        phase = 4;
                    end
                    default: ;
                endcase
            end
            if (done) job_done = 1;
            if (in_valid && in_ready) bi++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_bytes.push_back(out_bytes);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; perm_spur = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_len0();
        model_job(32'd0, 1'b0);
        run_job(32'd0, 1'b0, 0, 0);
        n_checks++;
        if (!job_done || mon_dones != 1) begin
            n_fail++;
            $display("FAIL len0_done: done pulses %0d required 1", mon_dones);
        end
        n_checks++;
        if (mon_pe_pos.size() != 1 || mon_pe_pos[0] != 0) begin
            n_fail++;
            $display("FAIL len0_process: count %0d required 1 at position 0", mon_pe_pos.size());
        end
        n_checks++;
        if (mon_ov != 0 || mon_perm_starts != 0) begin
            n_fail++;
            $display("FAIL len0_no_beat: out_valid cycles %0d perm_starts %0d required 0 0",
                     mon_ov, mon_perm_starts);
        end
        // start cycle, LAST, then DONE in the third cycle
        n_checks++;
        if (mon_done_cyc - start_cyc != 2) begin
            n_fail++;
            $display("FAIL len0_latency: done %0d cycles after start required 2",
                     mon_done_cyc - start_cyc);
        end
    endtask

    task automatic test_len32();
        perm_lat = 8;
        model_job(32'd32, 1'b0);
        run_job(32'd32, 1'b0, 0, 0);
        n_checks++;
        if (mon_perm_starts != 2) begin
            n_fail++;
            $display("FAIL len32_perm_starts: got %0d required 2", mon_perm_starts);
        end
        n_checks++;
        if (mon_pe_pos.size() != 3 || mon_pe_pos[2] != 32) begin
            n_fail++;
            $display("FAIL len32_padding: %0d process steps required 3 ending at 32",
                     mon_pe_pos.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_bytes.size() || got_bytes[i] !== 5'd16 || got_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL len32_beat%0d: got %0d beats required 2 of 16 bytes", i,
                         got_bytes.size());
            end
        end
        n_checks++;
        if (!job_done || mon_dones != 1 || mon_len !== 32'd32) begin
            n_fail++;
            $display("FAIL len32_done: dones %0d length %0d required 1 32", mon_dones, mon_len);
        end
    endtask

    task automatic test_len20();
        perm_lat = 3;
        model_job(32'd20, 1'b1);
        run_job(32'd20, 1'b1, 0, 0);
        n_checks++;
        if (mon_perm_starts != 1) begin
            n_fail++;
            $display("FAIL len20_perm_starts: got %0d required 1", mon_perm_starts);
        end
        n_checks++;
        if (mon_pe_pos.size() != 2 || mon_pe_pos[1] != 16) begin
            n_fail++;
            $display("FAIL len20_last_pos: %0d process steps required 2 ending at 16",
                     mon_pe_pos.size());
        end
        n_checks++;
        if (got_bytes.size() != 2 || got_bytes[0] !== 5'd16 || got_bytes[1] !== 5'd4) begin
            n_fail++;
            $display("FAIL len20_bytes: got %0d beats required 16 then 4", got_bytes.size());
        end
        n_checks++;
        if (got_data.size() != 2 || got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1]
            || mon_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL len20_data: beat data or mode %b wrong, required mode 1", mon_mode);
        end
        n_checks++;
        if (mon_dones != 1) begin
            n_fail++;
            $display("FAIL len20_done: got %0d required 1", mon_dones);
        end
    endtask

    task automatic test_backpressure();
        perm_lat = 5;
        model_job(32'd32, 1'b0);
        run_job(32'd32, 1'b0, 10, 0);
        n_checks++;
        if (bp_cycles != 10 || bp_bad != 0) begin
            n_fail++;
            $display("FAIL backpressure: held %0d cycles with %0d bad required 10 and 0",
                     bp_cycles, bp_bad);
        end
        n_checks++;
        if (got_data.size() != 2 || got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1]) begin
            n_fail++;
            $display("FAIL backpressure_data: got %0d beats required 2 matching", got_data.size());
        end
    endtask

    task automatic test_reset_mid_perm();
        bit bad;
        perm_lat = 8;
        clear_mon();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; text_len = 32'd32;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_perm_outputs: got %h required 0", all_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_perm_idle: busy %b required 0", busy);
        end
        // The pending perm_done from the stand-in arrives during this window
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad || mon_dones != 0 || mon_pe_pos.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_perm_ignored: dones %0d process %0d busy_seen %0d required 0",
                     mon_dones, mon_pe_pos.size(), bad);
        end
    endtask

    task automatic test_spurious();
        perm_lat = 4;
        model_job(32'd32, 1'b0);
        run_job(32'd32, 1'b0, 0, 1);
        n_checks++;
        if (spur_hits != 2 || spur_bad != 0) begin
            n_fail++;
            $display("FAIL spurious_no_change: hits %0d bad %0d required 2 0", spur_hits, spur_bad);
        end
        n_checks++;
        if (mon_pe_pos.size() != 3 || mon_perm_starts != 2 || mon_len !== 32'd32 || mon_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_job: process %0d perms %0d len %0d required 3 2 32",
                     mon_pe_pos.size(), mon_perm_starts, mon_len);
        end
        n_checks++;
        if (!job_done || got_data.size() != 2 || got_data[1] !== exp_data[1]) begin
            n_fail++;
            $display("FAIL spurious_complete: beats %0d required 2 and done", got_data.size());
        end
    endtask

    task automatic test_random_jobs();
        logic [31:0] len;
        logic m;
        for (int j = 0; j < 8; j++) begin
            len = ($urandom_range(0, 3) == 0) ? 32'(16 * $urandom_range(0, 4))
                                              : 32'($urandom_range(1, 70));
            m = 1'($urandom);
            perm_lat = $urandom_range(1, 10);
            model_job(len, m);
            run_job(len, m, 0, 0);
            n_checks++;
            if (!job_done || mon_dones != 1 || mon_perm_starts != exp_nperm) begin
                n_fail++;
                $display("FAIL rand%0d_len%0d_flow: dones %0d perms %0d required 1 %0d", j, len,
                         mon_dones, mon_perm_starts, exp_nperm);
            end
            n_checks++;
            if (mon_pe_pos != exp_pe) begin
                n_fail++;
                $display("FAIL rand%0d_len%0d_positions: got %p required %p", j, len,
                         mon_pe_pos, exp_pe);
            end
            n_checks++;
            if (got_bytes != exp_bytes || got_data != exp_data) begin
                n_fail++;
                $display("FAIL rand%0d_len%0d_beats: bytes %p required %p", j, len,
                         got_bytes, exp_bytes);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_len0();
        test_len32();
        test_len20();
        test_backpressure();
        test_reset_mid_perm();
        test_spurious();
        test_random_jobs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
